subbytes_iter: RTL and testbench

- Parametrised, handshaked SubBytes/InvSubBytes engine for the AES datapath.
- Accepts one 128-bit state and substitutes LANES bytes per clock through LANES S-box lanes.
- Returns the result on a valid/ready output port.
- Trades area for latency; the mode bit selects encrypt (S-box) or decrypt (inverse S-box) per block.

---
 rtl/subbytes_iter.sv | 191 +++++++++++++++++++
 tb/tb_subbytes_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_iter.sv
// subbytes_iter: iterative AES SubBytes / InvSubBytes engine.
// A 128-bit state is captured, LANES bytes are substituted per clock through
// LANES S-box lanes, and the finished state is offered on a valid/ready port.

// Forward AES S-box: GF(2^8) multiplicative inverse followed by the affine map.
module sBox_8 (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out_enc
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv_b;

    // Field inverse then affine transform with constant 0x63
    always_comb begin
        inv_b        = gf_inv(sbox_in);
        sbox_out_enc = inv_b ^ {inv_b[6:0], inv_b[7]} ^ {inv_b[5:0], inv_b[7:6]}
                     ^ {inv_b[4:0], inv_b[7:5]} ^ {inv_b[3:0], inv_b[7:4]} ^ 8'h63;
    end
endmodule

module subbytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   work_next;
    logic           mode_q;
    logic           accept;
    logic           last_beat;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     fwd_out  [LANES];
    logic [7:0]     lane_out [LANES];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // InvSbox entry: inverse affine map (rot 1,3,6 xor 0x05) then field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign out_data  = work_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; ready held low throughout reset
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // One forward S-box and one inverse table per lane, selected by the block mode
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sBox_8 u_sbox (
            .sbox_in      (lane_in[l]),
            .sbox_out_enc (fwd_out[l])
        );
        assign lane_out[l] = mode_q ? inv_sbox(lane_in[l]) : fwd_out[l];
    end

    // Route the byte group addressed by the beat counter into the lanes
    always_comb begin
        int unsigned pos;
        pos = 0;
        for (int unsigned l = 0; l < LANES; l++) begin
            pos        = 15 - (32'(cnt_q) * LANES + l);
            lane_in[l] = work_q[8*pos +: 8];
        end
    end

    // Merge lane results back into the same byte positions; other bytes hold
    always_comb begin
        int unsigned pos;
        pos       = 0;
        work_next = work_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            pos                   = 15 - (32'(cnt_q) * LANES + l);
            work_next[8*pos +: 8] = lane_out[l];
        end
    end

    // Capture a block on acceptance, substitute one byte group per BUSY beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q <= in_data;
                        mode_q <= in_decrypt;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    work_q <= work_next;
                    cnt_q  <= last_beat ? '0 : cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_subbytes_iter.sv
// Bench for subbytes_iter: five instances (LANES 4,1,2,8,16) share clock,
// reset and data inputs; expected results go through a scoreboard queue.
module tb_subbytes_iter;
    localparam int unsigned NDUT = 5;
    localparam int unsigned NV   = 9;

    logic              clk;
    logic              rst_n;
    logic              in_decrypt;
    logic [127:0]      in_data;
    logic [NDUT-1:0]   in_valid_s;
    logic [NDUT-1:0]   in_ready_s;
    logic [NDUT-1:0]   out_valid_s;
    logic [NDUT-1:0]   out_ready_s;
    logic [NDUT-1:0]   busy_s;
    logic [127:0]      out_data_s [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        subbytes_iter #(.LANES(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid_s[g]),
            .in_ready   (in_ready_s[g]),
            .in_decrypt (in_decrypt),
            .in_data    (in_data),
            .out_valid  (out_valid_s[g]),
            .out_ready  (out_ready_s[g]),
            .out_data   (out_data_s[g]),
            .busy       (busy_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned  dut;
        logic         dec;
        logic [127:0] din;
        logic [127:0] dout;
        int unsigned  lat;
    } vec_t;

    typedef struct {
        int unsigned  dut;
        logic [127:0] data;
    } sb_t;

    vec_t        vecs [NV];
    sb_t         sb_q [$];
    int unsigned n_pass;
    int unsigned n_total;

    localparam logic [127:0] PT_B    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] CT_B    = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_S   = 128'h637c777bf26b6fc53001672bfed7ab76;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive a block and wait (bounded) for its acceptance; returns #1 after the accepting edge
    task automatic drive_accept(input int unsigned d, input logic dec, input logic [127:0] din,
                                input logic [127:0] dexp, input string tag);
        sb_t e;
        bit  ok;
        @(posedge clk); #1;
        in_data       = din;
        in_decrypt    = dec;
        in_valid_s[d] = 1'b1;
        e.dut  = d;
        e.data = dexp;
        sb_q.push_back(e);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready_s[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
        check({tag, "_accepted"}, 128'(ok), 128'd1);
    endtask

    // Count edges until out_valid, then compare latency and data against the scoreboard
    task automatic wait_output(input int unsigned d, input int unsigned lat_exp, input string tag);
        int unsigned lat;
        sb_t e;
        lat = 0;
        for (int unsigned n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid_s[d]) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_data: output seen with empty scoreboard", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, out_data_s[d], e.data);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{dut: 0, dec: 1'b0, din: PT_B,  dout: CT_B,           lat: 4};
        vecs[1] = '{dut: 0, dec: 1'b1, din: CT_B,  dout: PT_B,           lat: 4};
        vecs[2] = '{dut: 0, dec: 1'b1, din: '0,    dout: {16{8'h52}},    lat: 4};
        vecs[3] = '{dut: 0, dec: 1'b0, din: SEQ,   dout: SEQ_S,          lat: 4};
        vecs[4] = '{dut: 1, dec: 1'b0, din: SEQ,   dout: SEQ_S,          lat: 16};
        vecs[5] = '{dut: 2, dec: 1'b0, din: SEQ,   dout: SEQ_S,          lat: 8};
        vecs[6] = '{dut: 3, dec: 1'b0, din: SEQ,   dout: SEQ_S,          lat: 2};
        vecs[7] = '{dut: 4, dec: 1'b0, din: SEQ,   dout: SEQ_S,          lat: 1};
        vecs[8] = '{dut: 4, dec: 1'b1, din: SEQ_S, dout: SEQ,            lat: 1};

        rst_n       = 1'b0;
        in_valid_s  = '0;
        out_ready_s = '1;
        in_data     = '0;
        in_decrypt  = 1'b0;

        #2;
        check("ready_low_in_reset", 128'(in_ready_s), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready",  128'(in_ready_s[0]),  128'd1);
        check("reset_out_valid", 128'(out_valid_s[0]), 128'd0);
        check("reset_out_data",  out_data_s[0],        128'd0);
        check("reset_busy",      128'(busy_s),         128'd0);

        // Table-driven single blocks across modes and lane counts
        for (int i = 0; i < NV; i++) begin
            drive_accept(vecs[i].dut, vecs[i].dec, vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
            wait_output(vecs[i].dut, vecs[i].lat, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_drop", i), 128'(out_valid_s[vecs[i].dut]), 128'd0);
        end

        // Backpressure: result held for 10 cycles while a second block waits
        out_ready_s[0] = 1'b0;
        drive_accept(0, 1'b0, PT_B, CT_B, "bp_a");
        wait_output(0, 4, "bp_a");
        in_data       = CT_B;
        in_decrypt    = 1'b1;
        in_valid_s[0] = 1'b1;
        begin
            sb_t e;
            e.dut  = 0;
            e.data = PT_B;
            sb_q.push_back(e);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_flags", c),
                  128'({out_valid_s[0], in_ready_s[0], busy_s[0]}), 128'(3'b101));
            check($sformatf("bp_hold%0d_data", c), out_data_s[0], CT_B);
        end
        out_ready_s[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_after_handshake_flags",
              128'({out_valid_s[0], in_ready_s[0], busy_s[0]}), 128'(3'b010));
        @(posedge clk); #1;
        check("bp_second_accepted_flags",
              128'({out_valid_s[0], in_ready_s[0], busy_s[0]}), 128'(3'b001));
        in_valid_s[0] = 1'b0;
        wait_output(0, 4, "bp_b");
        @(posedge clk); #1;

        // Reset pulse during beat 2 of a decrypt block discards it
        @(posedge clk); #1;
        in_data       = CT_B;
        in_decrypt    = 1'b1;
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        check("mr_accepted_busy", 128'(busy_s[0]), 128'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mr_busy",      128'(busy_s[0]),      128'd0);
        check("mr_out_valid", 128'(out_valid_s[0]), 128'd0);
        check("mr_in_ready",  128'(in_ready_s[0]),  128'd0);
        check("mr_out_data",  out_data_s[0],        128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_accept(0, 1'b0, {16{8'h53}}, {16{8'hed}}, "mr_next");
        wait_output(0, 4, "mr_next");
        @(posedge clk); #1;
        check("mr_next_valid_drop", 128'(out_valid_s[0]), 128'd0);

        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
